// File: rtl/bike_turn_ctrl_pkg.sv
// Shared game encodings for heading and turn requests, plus the heading update helper.
package bike_turn_ctrl_pkg;

    localparam int unsigned DIR_W = 2;

    // Heading encoding, counter-clockwise order so a ccw turn is +1 mod 4
    localparam logic [DIR_W-1:0] DIR_PX = 2'd0;
    localparam logic [DIR_W-1:0] DIR_NY = 2'd1;
    localparam logic [DIR_W-1:0] DIR_NX = 2'd2;
    localparam logic [DIR_W-1:0] DIR_PY = 2'd3;

    // Turn request encoding as stored in the request queue
    localparam logic TURN_CCW = 1'b0;
    localparam logic TURN_CW  = 1'b1;

    // Apply one turn to a heading; 2-bit arithmetic gives the mod-4 wrap
    function automatic logic [DIR_W-1:0] turn_dir(input logic [DIR_W-1:0] dir,
                                                  input logic             turn);
        logic [DIR_W-1:0] res;
        if (turn == TURN_CCW) begin
            res = dir + 2'd1;
        end else begin
            res = dir - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bike_turn_ctrl_button_debounce.sv
// Button conditioning: two-flop synchronizer, counting debouncer, rising-edge pulse.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // Synchronize the raw level, then accept it only after it has held for the full window
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            press   <= level & ~level_d;
            // Counter only runs while the input disagrees with the accepted level
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bike_turn_ctrl.sv
// Turn controller: debounced buttons queue turn requests, each game tick applies one.
module bike_turn_ctrl
    import bike_turn_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned CNT_W           = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ccw,
    input  logic       btn_cw,
    input  logic       tick,
    input  logic       load,
    input  logic [1:0] init_dir,
    output logic [1:0] direction,
    output logic       turn_applied,
    output logic [2:0] q_count,
    output logic       overflow
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [2:0]       CNT_FULL = 3'(FIFO_DEPTH);

    logic press_ccw;
    logic press_cw;

    logic [DIR_W-1:0]      dir_q,     dir_nxt;
    logic [2:0]            count_q,   count_nxt;
    logic [PTR_W-1:0]      wr_ptr_q,  wr_ptr_nxt;
    logic [PTR_W-1:0]      rd_ptr_q,  rd_ptr_nxt;
    logic [FIFO_DEPTH-1:0] mem_q,     mem_nxt;
    logic                  ovf_q,     ovf_nxt;
    logic                  applied_q, applied_nxt;

    logic push_req;
    logic full;
    logic empty;
    logic do_pop;
    logic do_push;
    logic drop;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb_ccw (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_ccw),
        .press (press_ccw)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb_cw (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_cw),
        .press (press_cw)
    );

    // Wrap a queue pointer modulo FIFO_DEPTH (depth need not be a power of two)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_LAST) begin
            r = '0;
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // Next-state: load flush, queue push/pop and heading update
    always_comb begin
        dir_nxt     = dir_q;
        count_nxt   = count_q;
        wr_ptr_nxt  = wr_ptr_q;
        rd_ptr_nxt  = rd_ptr_q;
        mem_nxt     = mem_q;
        ovf_nxt     = ovf_q;
        applied_nxt = 1'b0;

        // Simultaneous presses cancel each other
        push_req = press_ccw ^ press_cw;
        full     = (count_q == CNT_FULL);
        empty    = (count_q == 3'd0);
        // Pop only an entry already present, so an empty queue never bypasses
        do_pop   = tick & ~empty;
        // A pop frees the head slot, so a full queue can still accept a push
        do_push  = push_req & (~full | do_pop);
        drop     = push_req & full & ~do_pop;

        if (load) begin
            dir_nxt    = init_dir;
            count_nxt  = 3'd0;
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            ovf_nxt    = 1'b0;
        end else begin
            if (do_pop) begin
                dir_nxt     = turn_dir(dir_q, mem_q[rd_ptr_q]);
                rd_ptr_nxt  = ptr_inc(rd_ptr_q);
                applied_nxt = 1'b1;
            end
            if (do_push) begin
                mem_nxt[wr_ptr_q] = press_cw ? TURN_CW : TURN_CCW;
                wr_ptr_nxt        = ptr_inc(wr_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_nxt = count_q + 3'd1;
            end else if (do_pop && !do_push) begin
                count_nxt = count_q - 3'd1;
            end
            if (drop) begin
                ovf_nxt = 1'b1;
            end
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q     <= DIR_PX;
            count_q   <= 3'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_q     <= '0;
            ovf_q     <= 1'b0;
            applied_q <= 1'b0;
        end else begin
            dir_q     <= dir_nxt;
            count_q   <= count_nxt;
            wr_ptr_q  <= wr_ptr_nxt;
            rd_ptr_q  <= rd_ptr_nxt;
            mem_q     <= mem_nxt;
            ovf_q     <= ovf_nxt;
            applied_q <= applied_nxt;
        end
    end

    assign direction    = dir_q;
    assign turn_applied = applied_q;
    assign q_count      = count_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_bike_turn_ctrl.sv
// Directed bench for bike_turn_ctrl with a reference queue model and expected-heading scoreboard.
module tb_bike_turn_ctrl;

    logic       clk;
    logic       reset;
    logic       btn_ccw;
    logic       btn_cw;
    logic       tick;
    logic       load;
    logic [1:0] init_dir;
    logic [1:0] direction;
    logic       turn_applied;
    logic [2:0] q_count;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit         model_q[$];
    logic [1:0] exp_q[$];
    logic [1:0] model_dir;
    logic       model_ovf;

    bike_turn_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .FIFO_DEPTH      (4),
        .CNT_W           (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_ccw      (btn_ccw),
        .btn_cw       (btn_cw),
        .tick         (tick),
        .load         (load),
        .init_dir     (init_dir),
        .direction    (direction),
        .turn_applied (turn_applied),
        .q_count      (q_count),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_queue(input string tag);
        check({tag, "_q_count"}, 8'(q_count), 8'(model_q.size()));
        check({tag, "_overflow"}, 8'(overflow), 8'(model_ovf));
    endtask

    // Hold a button long enough to debounce, release it, and record the expected push
    task automatic press(input bit cw, input string tag);
        if (cw) btn_cw = 1'b1; else btn_ccw = 1'b1;
        repeat (10) step();
        btn_cw  = 1'b0;
        btn_ccw = 1'b0;
        repeat (10) step();
        if (model_q.size() < 4) model_q.push_back(cw);
        else model_ovf = 1'b1;
        check_queue(tag);
    endtask

    // One game tick; the expected heading is queued before the DUT reacts
    task automatic do_tick(input string tag);
        bit   t;
        logic exp_applied;
        exp_applied = 1'b0;
        tick = 1'b1;
        if (model_q.size() > 0) begin
            t = model_q.pop_front();
            model_dir = t ? model_dir - 2'd1 : model_dir + 2'd1;
            exp_q.push_back(model_dir);
            exp_applied = 1'b1;
        end
        step();
        tick = 1'b0;
        check({tag, "_applied"}, 8'(turn_applied), 8'(exp_applied));
        if (exp_q.size() > 0) begin
            check({tag, "_dir"}, 8'(direction), 8'(exp_q.pop_front()));
        end else begin
            check({tag, "_dir_hold"}, 8'(direction), 8'(model_dir));
        end
        check({tag, "_q_count"}, 8'(q_count), 8'(model_q.size()));
        step();
        check({tag, "_pulse_end"}, 8'(turn_applied), 8'd0);
    endtask

    task automatic model_reset(input logic [1:0] d);
        model_q.delete();
        exp_q.delete();
        model_dir = d;
        model_ovf = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        btn_ccw  = 1'b0;
        btn_cw   = 1'b0;
        tick     = 1'b0;
        load     = 1'b0;
        init_dir = 2'd0;
        model_reset(2'd0);
        repeat (3) step();
        check("rst_dir", 8'(direction), 8'd0);
        check("rst_applied", 8'(turn_applied), 8'd0);
        check_queue("rst");
        reset = 1'b0;
        step();

        // Single ccw press then tick: heading 0 -> 1
        press(1'b0, "ccw1");
        do_tick("tick_ccw1");

        // Two-cycle glitch on cw must not be accepted
        btn_cw = 1'b1;
        repeat (2) step();
        btn_cw = 1'b0;
        repeat (10) step();
        check_queue("glitch");

        // Re-home to +x via load
        init_dir = 2'd0;
        load = 1'b1;
        step();
        load = 1'b0;
        model_reset(2'd0);
        check("load0_dir", 8'(direction), 8'd0);

        // Five presses overflow a depth-4 queue
        for (int i = 0; i < 5; i++) press(1'b0, "fill");
        for (int i = 0; i < 4; i++) do_tick("drain");
        do_tick("drain_empty");

        // Simultaneous presses cancel
        btn_ccw = 1'b1;
        btn_cw  = 1'b1;
        repeat (10) step();
        btn_ccw = 1'b0;
        btn_cw  = 1'b0;
        repeat (10) step();
        check_queue("both");

        // Ordering: cw then ccw gives 3 then 0
        press(1'b1, "ord_cw");
        press(1'b0, "ord_ccw");
        do_tick("ord_t1");
        do_tick("ord_t2");

        // load beats a same-cycle tick and press pulse
        for (int i = 0; i < 3; i++) press(1'b0, "pre_load");
        btn_ccw = 1'b1;
        repeat (7) step();
        init_dir = 2'd2;
        load = 1'b1;
        tick = 1'b1;
        step();
        load = 1'b0;
        tick = 1'b0;
        model_reset(2'd2);
        check("load_dir", 8'(direction), 8'd2);
        check("load_applied", 8'(turn_applied), 8'd0);
        check_queue("load");
        btn_ccw = 1'b0;
        repeat (12) step();
        check_queue("load_press_discard");

        // Reset mid-operation with a queued pair and a debounce in progress
        press(1'b0, "pre_rst");
        press(1'b0, "pre_rst");
        btn_ccw = 1'b1;
        repeat (4) step();
        reset = 1'b1;
        btn_ccw = 1'b0;
        step();
        reset = 1'b0;
        model_reset(2'd0);
        check("mid_rst_dir", 8'(direction), 8'd0);
        check("mid_rst_applied", 8'(turn_applied), 8'd0);
        check_queue("mid_rst");
        do_tick("post_rst_tick");
        repeat (12) step();
        check_queue("post_rst_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
